svcs_hs_tx_framer: RTL

// - Synthesizable multi-channel transmit framer for SVCS client/server handshake traffic.
// - Arbitrates N_CH producers round-robin and serializes each transaction onto one word stream.
// - Frame: header {trnx_type, trnx_id, data_type, n_words}, then payload words, then an optional XOR trailer.
// - Sits between RTL transaction sources and the socket/DPI bridge; replaces per-type send calls with one framed stream.

---
 rtl/svcs_hs_pkg.sv | 27 ++
 rtl/svcs_rr_arb.sv | 32 +++
 rtl/svcs_hs_tx_framer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/svcs_hs_pkg.sv
// Shared types and constants for the SVCS handshake transmit framer.
// The descriptor struct is sized for the default stream and length widths.
package svcs_hs_pkg;

  localparam int HDR_WORDS   = 4;
  localparam int DESC_DATA_W = 32;
  localparam int DESC_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    TRL
  } svcs_fr_state_e;

  typedef struct packed {
    logic [DESC_DATA_W-1:0] trnx_type;
    logic [DESC_DATA_W-1:0] data_type;
    logic [DESC_LEN_W-1:0]  len;
  } svcs_fr_desc_t;

  // Index width that stays at least one bit for a single-entry selector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svcs_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module svcs_rr_arb
  import svcs_hs_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  // NOTE: every output gets a default before the search so no path infers a latch.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svcs_hs_tx_framer.sv
// Multi-channel transmit framer: round-robin picks a producer descriptor and
// serialises header, payload pass-through and optional XOR trailer onto one stream.
module svcs_hs_tx_framer
  import svcs_hs_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_W     = 32,
  parameter  int LEN_W      = 16,
  parameter  int ID_W       = 16,
  parameter  bit TRAILER_EN = 1'b1,
  localparam int CH_W       = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [N_CH-1:0]        ch_ready,
  input  logic [N_CH*DATA_W-1:0] ch_trnx_type,
  input  logic [N_CH*DATA_W-1:0] ch_data_type,
  input  logic [N_CH*LEN_W-1:0]  ch_len,
  input  logic [N_CH-1:0]        ch_dvalid,
  output logic [N_CH-1:0]        ch_dready,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   busy,
  output logic [CH_W-1:0]        cur_ch
);

  svcs_fr_state_e  state_q, state_d;
  svcs_fr_desc_t   desc_q;
  logic [CH_W-1:0] gnt_q, rr_ptr_q, gnt_idx;
  logic [N_CH-1:0] gnt;
  logic            gnt_any;
  logic [1:0]      hdr_idx_q;
  logic [LEN_W-1:0] pay_cnt_q, len_q;
  logic [ID_W-1:0]  trnx_id_q;
  logic [DATA_W-1:0] csum_q;
  logic start, xfer, hdr_last, last_pay;

  svcs_rr_arb #(.N(N_CH)) u_arb (
    .req     (ch_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign len_q    = LEN_W'(desc_q.len);
  assign start    = (state_q == IDLE) && gnt_any;
  assign xfer     = out_valid && out_ready;
  assign hdr_last = (hdr_idx_q == 2'(HDR_WORDS - 1));
  assign last_pay = (pay_cnt_q == len_q - LEN_W'(1));
  assign busy     = (state_q != IDLE);
  assign cur_ch   = gnt_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_any) state_d = HDR;
      HDR: begin
        if (xfer && hdr_last) begin
          if (len_q != '0)     state_d = PAY;
          else if (TRAILER_EN) state_d = TRL;
          else                 state_d = IDLE;
        end
      end
      PAY: begin
        if (xfer && last_pay) state_d = TRAILER_EN ? TRL : IDLE;
      end
      TRL:     if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_ready  = '0;
    ch_dready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    case (state_q)
      // Grant is combinational; masked while reset is held so nothing is accepted.
      IDLE: ch_ready = rst ? '0 : gnt;
      HDR: begin
        out_valid = 1'b1;
        out_sop   = (hdr_idx_q == 2'd0);
        out_eop   = hdr_last && (len_q == '0) && !TRAILER_EN;
        case (hdr_idx_q)
          2'd0:    out_data = DATA_W'(desc_q.trnx_type);
          2'd1:    out_data = DATA_W'(trnx_id_q);
          2'd2:    out_data = DATA_W'(desc_q.data_type);
          default: out_data = DATA_W'(len_q);
        endcase
      end
      PAY: begin
        out_valid        = ch_dvalid[gnt_q];
        ch_dready[gnt_q] = out_ready;
        out_data         = ch_data[int'(gnt_q)*DATA_W +: DATA_W];
        out_eop          = last_pay && !TRAILER_EN;
      end
      TRL: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_eop   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desc_q    <= '0;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      hdr_idx_q <= '0;
      pay_cnt_q <= '0;
      trnx_id_q <= '0;
      csum_q    <= '0;
    end else begin
      if (start) begin
        desc_q.trnx_type <= DESC_DATA_W'(ch_trnx_type[int'(gnt_idx)*DATA_W +: DATA_W]);
        desc_q.data_type <= DESC_DATA_W'(ch_data_type[int'(gnt_idx)*DATA_W +: DATA_W]);
        desc_q.len       <= DESC_LEN_W'(ch_len[int'(gnt_idx)*LEN_W +: LEN_W]);
        gnt_q            <= gnt_idx;
        rr_ptr_q         <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        hdr_idx_q        <= '0;
        pay_cnt_q        <= '0;
        csum_q           <= '0;
      end
      // Start and transfer never coincide: IDLE presents no stream word.
      if (xfer) begin
        csum_q <= csum_q ^ out_data;
        if (state_q == HDR) hdr_idx_q <= hdr_idx_q + 2'd1;
        if (state_q == PAY) pay_cnt_q <= pay_cnt_q + LEN_W'(1);
        if (out_eop)        trnx_id_q <= trnx_id_q + ID_W'(1);
      end
    end
  end

endmodule
